costas_acq_ctrl: RTL and testbench

COSTAS_ACQ_CTRL -- requirements
Module: costas_acq_ctrl

---
 rtl/costas_ctrl_pkg.sv | 26 ++
 rtl/costas_bin_ftw.sv | 27 ++
 rtl/costas_acq_ctrl.sv | 136 +++++++++++++
 tb/tb_costas_acq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/costas_ctrl_pkg.sv
// Costas acquisition controller: shared state type and default constants.
package costas_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_DWELL,
        S_TRACK,
        S_FAIL
    } state_t;

    localparam logic [31:0] DEF_FTW_CENTER  = 32'h1999_999A;
    localparam logic [31:0] DEF_FTW_STEP    = 32'h0010_0000;
    localparam int          DEF_NUM_BINS    = 9;
    localparam int          DEF_RST_CYCLES  = 4;
    localparam int          DEF_DWELL       = 4096;
    localparam int          DEF_UNLOCK_HOLD = 256;
    localparam int          DEF_MAX_SWEEPS  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/costas_bin_ftw.sv
// Bin index to NCO tuning word; loaded on the edge that enters loop reset.
module costas_bin_ftw #(
    parameter logic [31:0] FTW_CENTER = 32'h1999_999A,
    parameter logic [31:0] FTW_STEP   = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  bin,
    output logic [31:0] ftw
);

    logic [7:0]  mag;
    logic [31:0] delta;

    // Odd bins step up by (n+1)/2, even bins step down by n/2.
    assign mag   = 8'((9'(bin) + 9'd1) >> 1);
    assign delta = 32'(mag) * FTW_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ftw <= FTW_CENTER;
        else if (load)
            ftw <= bin[0] ? FTW_CENTER + delta : FTW_CENTER - delta;
    end

endmodule

// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition sequencer: frequency-bin sweep, dwell, track, fail.
module costas_acq_ctrl
    import costas_ctrl_pkg::*;
#(
    parameter logic [31:0] FTW_CENTER   = DEF_FTW_CENTER,
    parameter logic [31:0] FTW_STEP     = DEF_FTW_STEP,
    parameter int          NUM_BINS     = DEF_NUM_BINS,
    parameter int          RST_CYCLES   = DEF_RST_CYCLES,
    parameter int          DWELL_CYCLES = DEF_DWELL,
    parameter int          UNLOCK_HOLD  = DEF_UNLOCK_HOLD,
    parameter int          MAX_SWEEPS   = DEF_MAX_SWEEPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        locked,
    output logic        loop_rst,
    output logic [31:0] ftw_out,
    output logic [7:0]  bin_idx,
    output logic        acquired,
    output logic        lost,
    output logic        search_fail
);

    localparam int CMAX = max3(RST_CYCLES, DWELL_CYCLES, UNLOCK_HOLD);
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    bin_nxt;
    logic [7:0]    sweep, sweep_nxt;
    logic          locked_q;
    logic          lost_nxt;
    logic          ftw_load;

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_idx;
        sweep_nxt = sweep;
        lost_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                bin_nxt   = 8'd0;
                sweep_nxt = 8'd0;
                if (start)
                    state_nxt = S_LRST;
            end
            S_LRST: begin
                if (cnt == CW'(RST_CYCLES - 1))
                    state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (locked_q) begin
                    state_nxt = S_TRACK;
                end else if (cnt == CW'(DWELL_CYCLES - 1)) begin
                    if (bin_idx == 8'(NUM_BINS - 1)) begin
                        bin_nxt   = 8'd0;
                        sweep_nxt = sweep + 8'd1;
                        state_nxt = (sweep_nxt == 8'(MAX_SWEEPS)) ? S_FAIL : S_LRST;
                    end else begin
                        bin_nxt   = bin_idx + 8'd1;
                        state_nxt = S_LRST;
                    end
                end
            end
            S_TRACK: begin
                if (!locked_q && cnt == CW'(UNLOCK_HOLD - 1)) begin
                    lost_nxt  = 1'b1;
                    sweep_nxt = 8'd0;
                    state_nxt = S_LRST;
                end
            end
            S_FAIL: begin
                if (start) begin
                    bin_nxt   = 8'd0;
                    sweep_nxt = 8'd0;
                    state_nxt = S_LRST;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            bin_nxt   = 8'd0;
            sweep_nxt = 8'd0;
            lost_nxt  = 1'b0;
        end
    end

    // One counter serves reset length, dwell time and unlocked run length.
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        if (state_nxt != state || state == S_IDLE || state == S_FAIL
            || (state == S_TRACK && locked_q))
            cnt_nxt = '0;
    end

    assign ftw_load = (state_nxt == S_LRST) && (state != S_LRST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sweep       <= 8'd0;
            locked_q    <= 1'b0;
            bin_idx     <= 8'd0;
            loop_rst    <= 1'b1;
            acquired    <= 1'b0;
            lost        <= 1'b0;
            search_fail <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sweep       <= sweep_nxt;
            locked_q    <= (state == S_DWELL || state == S_TRACK) && locked;
            bin_idx     <= bin_nxt;
            loop_rst    <= (state_nxt == S_IDLE) || (state_nxt == S_LRST);
            acquired    <= (state_nxt == S_TRACK);
            lost        <= lost_nxt;
            search_fail <= (state_nxt == S_FAIL);
        end
    end

    costas_bin_ftw #(
        .FTW_CENTER(FTW_CENTER),
        .FTW_STEP  (FTW_STEP)
    ) u_bin_ftw (
        .clk (clk),
        .rst (rst),
        .load(ftw_load),
        .bin (bin_nxt),
        .ftw (ftw_out)
    );

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Bench for costas_acq_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_costas_acq_ctrl;

    localparam logic [31:0] FC = 32'h1999_999A;
    localparam logic [31:0] FS = 32'h0010_0000;
    localparam int NB = 9;
    localparam int RC = 4;
    localparam int DW = 16;
    localparam int UH = 256;
    localparam int MS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, abort, locked;
    logic        loop_rst, acquired, lost, search_fail;
    logic [31:0] ftw_out;
    logic [7:0]  bin_idx;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    costas_acq_ctrl #(
        .FTW_CENTER(FC), .FTW_STEP(FS), .NUM_BINS(NB), .RST_CYCLES(RC),
        .DWELL_CYCLES(DW), .UNLOCK_HOLD(UH), .MAX_SWEEPS(MS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .locked(locked),
        .loop_rst(loop_rst), .ftw_out(ftw_out), .bin_idx(bin_idx),
        .acquired(acquired), .lost(lost), .search_fail(search_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RST, M_DWELL, M_TRACK, M_FAIL} mst_t;
    mst_t        m_st = M_IDLE;
    int          m_bin = 0, m_sweep = 0, m_left = 0, m_age = 0, m_miss = 0;
    bit          m_lk = 0, m_lost = 0, lk_prev;
    logic [31:0] m_ftw = FC;

    function automatic logic [31:0] ftw_of(input int n);
        int off;
        logic [31:0] o;
        off = (n == 0) ? 0 : ((n % 2) != 0) ? (n + 1) / 2 : -(n / 2);
        o = off;
        return FC + o * FS;
    endfunction

    task automatic go_reset(input int b);
        m_bin  = b;
        m_st   = M_RST;
        m_left = RC;
        m_ftw  = ftw_of(b);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = M_IDLE; m_bin = 0; m_sweep = 0; m_left = 0; m_age = 0;
            m_miss = 0; m_lk = 0; m_lost = 0; m_ftw = FC;
        end else begin
            lk_prev = m_lk;
            m_lk = (m_st == M_DWELL || m_st == M_TRACK) ? locked : 1'b0;
            m_lost = 0;
            if (abort) begin
                m_st = M_IDLE; m_bin = 0; m_sweep = 0;
            end else begin
                case (m_st)
                    M_IDLE: begin
                        m_bin = 0; m_sweep = 0;
                        if (start) go_reset(0);
                    end
                    M_FAIL: if (start) begin m_sweep = 0; go_reset(0); end
                    M_RST: begin
                        m_left--;
                        if (m_left == 0) begin m_st = M_DWELL; m_age = 0; end
                    end
                    M_DWELL: begin
                        m_age++;
                        if (lk_prev) begin
                            m_st = M_TRACK; m_miss = 0;
                        end else if (m_age == DW) begin
                            if (m_bin == NB - 1) begin
                                m_sweep++;
                                if (m_sweep == MS) begin m_bin = 0; m_st = M_FAIL; end
                                else go_reset(0);
                            end else go_reset(m_bin + 1);
                        end
                    end
                    M_TRACK: begin
                        if (lk_prev) m_miss = 0; else m_miss++;
                        if (m_miss == UH) begin m_lost = 1; m_sweep = 0; go_reset(m_bin); end
                    end
                    default: m_st = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("loop_rst", loop_rst, (m_st == M_IDLE || m_st == M_RST));
            check("ftw_out", ftw_out, m_ftw);
            check("bin_idx", bin_idx, 32'(m_bin));
            check("acquired", acquired, (m_st == M_TRACK));
            check("lost", lost, m_lost);
            check("search_fail", search_fail, (m_st == M_FAIL));
        end
    end

    // ---------------- directed sequence ----------------
    logic [31:0] lit [4] = '{32'h1999_999A, 32'h19A9_999A, 32'h1989_999A, 32'h19B9_999A};
    logic [7:0]  seen [$];
    logic [7:0]  last;
    logic [31:0] packed_seen;
    int          lost_cnt, dwells;
    logic        lost_bin_ok, lost_rst_ok, prev;

    task automatic reset_vals(input string tag);
        check({tag, "_loop_rst"}, loop_rst, 1'b1);
        check({tag, "_ftw"}, ftw_out, FC);
        check({tag, "_bin"}, bin_idx, 8'd0);
        check({tag, "_acquired"}, acquired, 1'b0);
        check({tag, "_lost"}, lost, 1'b0);
        check({tag, "_search_fail"}, search_fail, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; abort = 0; locked = 0;
        #1 rst = 1; chk_on = 1;
        @(negedge clk);
        reset_vals("rst");
        @(negedge clk);
        rst = 0;

        // locked held high: reset pulse then acquisition at cycle 7
        locked = 1; start = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            check("t1_loop_rst", loop_rst, (k <= 4));
            check("t1_acquired", acquired, (k >= 7));
        end
        check("t1_ftw", ftw_out, 32'h1999_999A);

        abort = 1; locked = 0;
        @(negedge clk);
        abort = 0;
        check("abort_idle_rst", loop_rst, 1'b1);
        check("abort_idle_acq", acquired, 1'b0);

        // lock first appears in bin 3
        start = 1;
        @(negedge clk);
        start = 0;
        seen.delete();
        seen.push_back(bin_idx);
        last = bin_idx;
        for (int i = 0; i < 200 && bin_idx != 8'd3; i++) begin
            @(negedge clk);
            if (bin_idx != last) begin
                seen.push_back(bin_idx);
                last = bin_idx;
                if (bin_idx < 8'd4) check("t2_bin_ftw", ftw_out, lit[bin_idx[1:0]]);
            end
        end
        locked = 1;
        for (int i = 0; i < 40 && !acquired; i++) @(negedge clk);
        check("t2_acquired", acquired, 1'b1);
        check("t2_bin", bin_idx, 8'd3);
        check("t2_nvisited", seen.size(), 4);
        packed_seen = 0;
        foreach (seen[i]) packed_seen = {packed_seen[23:0], seen[i]};
        check("t2_visited", packed_seen, 32'h0001_0203);

        // unlock shorter than hold: no loss
        repeat (4) @(negedge clk);
        lost_cnt = 0;
        locked = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (lost) lost_cnt++;
        end
        locked = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lost) lost_cnt++;
        end
        check("t3_no_lost", lost_cnt, 0);
        check("t3_still_acq", acquired, 1'b1);

        // unlock for full hold: one lost pulse, reset at same bin
        lost_cnt = 0; lost_bin_ok = 0; lost_rst_ok = 0;
        locked = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (lost) lost_cnt++;
        end
        locked = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lost) begin
                lost_cnt++;
                lost_bin_ok = (bin_idx == 8'd3);
                lost_rst_ok = loop_rst;
            end
        end
        check("t3_lost_once", lost_cnt, 1);
        check("t3_lost_bin", lost_bin_ok, 1'b1);
        check("t3_lost_lrst", lost_rst_ok, 1'b1);

        // abort during dwell of bin 5
        abort = 1; locked = 0;
        @(negedge clk);
        abort = 0; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 300 && !(bin_idx == 8'd5 && !loop_rst); i++) @(negedge clk);
        check("t4_in_bin5_dwell", {bin_idx, 7'd0, loop_rst}, {8'd5, 8'd0});
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("t4_abort_acq", acquired, 1'b0);
        check("t4_abort_lrst", loop_rst, 1'b1);
        start = 1;
        @(negedge clk);
        start = 0;
        check("t4_restart_bin", bin_idx, 8'd0);
        check("t4_restart_lrst", loop_rst, 1'b1);
        check("t4_restart_ftw", ftw_out, FC);

        // never locks: 27 dwells then failure
        dwells = 0;
        prev = loop_rst;
        for (int i = 0; i < 1000 && !search_fail; i++) begin
            @(negedge clk);
            if (prev && !loop_rst) dwells++;
            prev = loop_rst;
        end
        check("t5_search_fail", search_fail, 1'b1);
        check("t5_dwells", dwells, 27);
        start = 1;
        @(negedge clk);
        start = 0;
        check("t5_restart_bin", bin_idx, 8'd0);
        check("t5_restart_lrst", loop_rst, 1'b1);
        check("t5_restart_sf", search_fail, 1'b0);

        // asynchronous reset in the middle of a dwell
        for (int i = 0; i < 200 && !(bin_idx == 8'd2 && !loop_rst); i++) @(negedge clk);
        check("t6_in_bin2_dwell", {bin_idx, 7'd0, loop_rst}, {8'd2, 8'd0});
        @(posedge clk);
        #3 rst = 1;
        #1 reset_vals("async");
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
